rf_ldst_dma: RTL and testbench
==============================

Name: rf_ldst_dma

Overview:
Multi-line DMA engine that moves vector lines between the Avalon-MM SDRAM port and the wide vector register file (RF).
Generalises the single-ratio load/store unit in four ways:
- parametric SDRAM/RF widths with a non-integer width ratio;
- per-command SDRAM line stride;
- zero-padded partial last beat;
- busy/done command handshake.
Sits between the NPU sequencer (master) and the SDRAM controller; the RF is the only local client.

Parameters:
SDRAM_ADDR_W, 25, SDRAM byte-address width
SDRAM_DATA_W, 128, Avalon data width (multiple of 8)
RF_ADDR_W, 9, RF line-address width
RF_DATA_W, 1408, RF line width (multiple of 8)
BEATS, ceil(RF_DATA_W/SDRAM_DATA_W), derived localparam: beats per line and avm_burstcount value
LINE_CNT_W, 8, width of the line-count field

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cmd_sdram_addr  in  SDRAM_ADDR_W  first-line SDRAM byte address
cmd_rf_addr  in  RF_ADDR_W  first RF line
cmd_line_num  in  LINE_CNT_W  lines to move; 0 = no-op
cmd_stride  in  SDRAM_ADDR_W  byte increment between lines
cmd_load  in  1  start SDRAM->RF (1-cycle pulse)
cmd_store  in  1  start RF->SDRAM (1-cycle pulse)
busy  out  1  command in progress
done  out  1  1-cycle completion pulse
avm_address  out  SDRAM_ADDR_W  burst start address
avm_read  out  1  read request
avm_write  out  1  write beat valid
avm_writedata  out  SDRAM_DATA_W  write beat
avm_byteenable  out  SDRAM_DATA_W/8  byte mask
avm_burstcount  out  $clog2(BEATS)+1  always BEATS
avm_waitrequest  in  1  slave stall
avm_readdata  in  SDRAM_DATA_W  read beat
avm_readdatavalid  in  1  read beat valid
rf_addr  out  RF_ADDR_W  RF line address
rf_d  out  RF_DATA_W  RF write data
rf_we  out  1  RF write strobe
rf_re  out  1  RF read strobe; rf_q valid the following cycle
rf_q  in  RF_DATA_W  RF read data

Behaviour:
- Reset: state IDLE. All outputs 0 except avm_burstcount=BEATS and avm_byteenable=all ones. Line buffer, beat counter and line counter cleared.
- Reset mid-operation: immediate return to IDLE. No done pulse. Any outstanding burst is abandoned; the system reset covers the slave.
- Command capture (IDLE only): on cmd_load or cmd_store, latch all cmd_* fields.
  - cmd_load and cmd_store together: load wins.
  - cmd_* pulses while busy are ignored.
  - line_num=0: go to DONE directly with no bus or RF activity.
- busy=1 in every state except IDLE.
- done is asserted in DONE for exactly 1 cycle, then the FSM returns to IDLE. A new command is accepted on the cycle after done.
- Load path:
  - LD_REQ: drive avm_read=1 and avm_address=cur_addr; hold while avm_waitrequest=1. On the first cycle with waitrequest=0, go to LD_DATA.
  - LD_DATA: each readdatavalid stores readdata into line_buf[beat] and increments beat. When beat BEATS-1 is received, go to LD_WRF.
  - LD_WRF: rf_we=1 for 1 cycle, with rf_d=line_buf packed beat0 in the LSBs, truncated to RF_DATA_W. Then advance (see below).
- Store path:
  - ST_RRF: rf_re=1 for 1 cycle.
  - ST_CAP: latch rf_q into line_buf; the part of the top beat above RF_DATA_W is filled with 0.
  - ST_WR: avm_write=1, avm_writedata=line_buf[beat]. avm_address=cur_addr is held for the whole burst. beat advances only on cycles with waitrequest=0.
  - Last beat (beat = BEATS-1): byteenable masks the bytes above RF_DATA_W. For an exact ratio it is all ones.
  - After the last beat is accepted, advance.
- Advance (end of each line):
  - cur_addr += stride, mod 2^SDRAM_ADDR_W.
  - rf_addr += 1, mod 2^RF_ADDR_W (wraps silently).
  - lines_left -= 1 and beat is cleared.
  - If lines_left reaches 0, go to DONE; otherwise go to LD_REQ or ST_RRF.
- Load-path timing: readdatavalid arriving during LD_REQ (zero-latency slave) is still captured.
- Idle bus: no avm_read/avm_write outside the request/write states. avm_address=0 when not requesting.
- Latency with zero-wait slave and 1-cycle read-data latency:
  - load line = 1 (REQ) + BEATS + 1 (WRF) cycles;
  - store line = 2 + BEATS cycles.

Decomposition:
- Package rf_ldst_pkg: state_t enum {IDLE, LD_REQ, LD_DATA, LD_WRF, ST_RRF, ST_CAP, ST_WR, DONE} (3 bits), and a function beats(rf_w, sd_w) returning the ceiling ratio.
- Sub-module rf_line_buf: BEATS x SDRAM_DATA_W register array. It has a beat counter (clr/inc), a per-beat load from SDRAM, a whole-line load from RF with zero pad, a packed RF_DATA_W output and a beat-select output.

Test Plan:
1. Load, 3 lines, sdram_addr=0x100, stride=0x200, rf_addr=5, zero-wait slave -> bursts at 0x100/0x300/0x500, rf_we at addresses 5/6/7 with matching data, one done pulse, busy low afterwards.
2. Store, 2 lines, RF_DATA_W=1400, SDRAM_DATA_W=128 (BEATS=11) -> 22 write beats; byteenable on each line's last beat = 0x7FFF; top 8 bits of avm_writedata = 0.
3. Random waitrequest (50%) on a store of 4 lines -> no beat lost or duplicated; writedata/address stable while stalled; SDRAM model contents equal the RF lines.
4. line_num=0 load -> done 1 cycle after capture; no avm_read and no rf_we.
5. cmd_load and cmd_store in the same cycle -> load executes; a cmd_store pulse while busy is ignored; rf_addr=511 with 2 lines wraps to 0.
6. rst_n asserted during LD_DATA -> outputs return to reset values immediately, no done; a new load after reset completes correctly.

Source files
------------

// File: rtl/rf_ldst_pkg.sv
// Shared types for the SDRAM <-> vector register file line DMA.
package rf_ldst_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LD_REQ,
      LD_DATA,
      LD_WRF,
      ST_RRF,
      ST_CAP,
      ST_WR,
      DONE
   } state_t;

   function automatic int beats(input int rf_w, input int sd_w);
      return (rf_w + sd_w - 1) / sd_w;
   endfunction

endpackage

// File: rtl/rf_line_buf.sv
// One RF line held as SDRAM-width beats, with the beat counter that walks it.
module rf_line_buf
   import rf_ldst_pkg::*;
#(
   parameter int SDRAM_DATA_W = 128,
   parameter int RF_DATA_W    = 1408,
   parameter int BEATS        = beats(RF_DATA_W, SDRAM_DATA_W),
   parameter int BEAT_W       = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr,
   input  logic                    inc,
   input  logic                    beat_we,
   input  logic                    line_we,
   input  logic [SDRAM_DATA_W-1:0] beat_d,
   input  logic [RF_DATA_W-1:0]    line_d,
   output logic [BEAT_W-1:0]       beat,
   output logic [RF_DATA_W-1:0]    line_q,
   output logic [SDRAM_DATA_W-1:0] beat_q
);

   localparam int BUF_W = BEATS * SDRAM_DATA_W;

   logic [BUF_W-1:0] buf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_q <= '0;
         beat  <= '0;
      end else begin
         // zero-extension pads the top beat past the RF line
         if (line_we)
            buf_q <= BUF_W'(line_d);
         else if (beat_we)
            buf_q[int'(beat)*SDRAM_DATA_W +: SDRAM_DATA_W] <= beat_d;
         if (clr)
            beat <= '0;
         else if (inc)
            beat <= beat + BEAT_W'(1);
      end
   end

   assign line_q = buf_q[RF_DATA_W-1:0];
   assign beat_q = buf_q[int'(beat)*SDRAM_DATA_W +: SDRAM_DATA_W];

endmodule

// File: rtl/rf_ldst_dma.sv
// Multi-line DMA between the Avalon-MM SDRAM port and the vector RF.
module rf_ldst_dma
   import rf_ldst_pkg::*;
#(
   parameter int  SDRAM_ADDR_W = 25,
   parameter int  SDRAM_DATA_W = 128,
   parameter int  RF_ADDR_W    = 9,
   parameter int  RF_DATA_W    = 1408,
   parameter int  LINE_CNT_W   = 8,
   localparam int BEATS        = beats(RF_DATA_W, SDRAM_DATA_W)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [SDRAM_ADDR_W-1:0]   cmd_sdram_addr,
   input  logic [RF_ADDR_W-1:0]      cmd_rf_addr,
   input  logic [LINE_CNT_W-1:0]     cmd_line_num,
   input  logic [SDRAM_ADDR_W-1:0]   cmd_stride,
   input  logic                      cmd_load,
   input  logic                      cmd_store,
   output logic                      busy,
   output logic                      done,
   output logic [SDRAM_ADDR_W-1:0]   avm_address,
   output logic                      avm_read,
   output logic                      avm_write,
   output logic [SDRAM_DATA_W-1:0]   avm_writedata,
   output logic [SDRAM_DATA_W/8-1:0] avm_byteenable,
   output logic [$clog2(BEATS):0]    avm_burstcount,
   input  logic                      avm_waitrequest,
   input  logic [SDRAM_DATA_W-1:0]   avm_readdata,
   input  logic                      avm_readdatavalid,
   output logic [RF_ADDR_W-1:0]      rf_addr,
   output logic [RF_DATA_W-1:0]      rf_d,
   output logic                      rf_we,
   output logic                      rf_re,
   input  logic [RF_DATA_W-1:0]      rf_q
);

   localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int BE_W       = SDRAM_DATA_W / 8;
   localparam int BC_W       = $clog2(BEATS) + 1;
   localparam int LAST_BYTES = (RF_DATA_W - (BEATS - 1) * SDRAM_DATA_W) / 8;
   localparam logic [BE_W-1:0]   LAST_BE   = {BE_W{1'b1}} >> (BE_W - LAST_BYTES);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   state_t state_q, state_d;

   logic [SDRAM_ADDR_W-1:0] cur_addr, stride_q;
   logic [RF_ADDR_W-1:0]    rf_addr_q;
   logic [LINE_CNT_W-1:0]   lines_left;

   logic                    clr, inc, beat_we, line_we;
   logic                    start, adv;
   logic [BEAT_W-1:0]       beat;
   logic [RF_DATA_W-1:0]    line_q;
   logic [SDRAM_DATA_W-1:0] beat_q;
   logic                    last_beat, last_rx, last_line;

   rf_line_buf #(
      .SDRAM_DATA_W (SDRAM_DATA_W),
      .RF_DATA_W    (RF_DATA_W),
      .BEATS        (BEATS),
      .BEAT_W       (BEAT_W)
   ) u_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .inc     (inc),
      .beat_we (beat_we),
      .line_we (line_we),
      .beat_d  (avm_readdata),
      .line_d  (rf_q),
      .beat    (beat),
      .line_q  (line_q),
      .beat_q  (beat_q)
   );

   assign last_beat      = (beat == LAST_BEAT);
   assign last_rx        = avm_readdatavalid && last_beat;
   assign last_line      = (lines_left == LINE_CNT_W'(1));
   assign busy           = (state_q != IDLE);
   assign avm_burstcount = BC_W'(BEATS);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cur_addr   <= '0;
         stride_q   <= '0;
         rf_addr_q  <= '0;
         lines_left <= '0;
      end else begin
         state_q <= state_d;
         if (start) begin
            cur_addr   <= cmd_sdram_addr;
            stride_q   <= cmd_stride;
            rf_addr_q  <= cmd_rf_addr;
            lines_left <= cmd_line_num;
         end else if (adv) begin
            cur_addr   <= cur_addr + stride_q;
            rf_addr_q  <= rf_addr_q + RF_ADDR_W'(1);
            lines_left <= lines_left - LINE_CNT_W'(1);
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      avm_read       = 1'b0;
      avm_write      = 1'b0;
      avm_address    = '0;
      avm_writedata  = '0;
      avm_byteenable = '1;
      rf_we          = 1'b0;
      rf_re          = 1'b0;
      rf_addr        = '0;
      rf_d           = '0;
      done           = 1'b0;
      clr            = 1'b0;
      inc            = 1'b0;
      beat_we        = 1'b0;
      line_we        = 1'b0;
      start          = 1'b0;
      adv            = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cmd_load || cmd_store) begin
               start = 1'b1;
               clr   = 1'b1;
               if (cmd_line_num == '0)
                  state_d = DONE;
               else if (cmd_load)
                  state_d = LD_REQ;
               else
                  state_d = ST_RRF;
            end
         end
         LD_REQ: begin
            // a zero-latency slave may return data in the request cycle
            avm_read    = 1'b1;
            avm_address = cur_addr;
            beat_we     = avm_readdatavalid;
            inc         = avm_readdatavalid && !last_beat;
            if (!avm_waitrequest)
               state_d = last_rx ? LD_WRF : LD_DATA;
         end
         LD_DATA: begin
            beat_we = avm_readdatavalid;
            inc     = avm_readdatavalid && !last_beat;
            if (last_rx)
               state_d = LD_WRF;
         end
         LD_WRF: begin
            rf_we   = 1'b1;
            rf_addr = rf_addr_q;
            rf_d    = line_q;
            adv     = 1'b1;
            clr     = 1'b1;
            state_d = last_line ? DONE : LD_REQ;
         end
         ST_RRF: begin
            rf_re   = 1'b1;
            rf_addr = rf_addr_q;
            state_d = ST_CAP;
         end
         ST_CAP: begin
            line_we = 1'b1;
            state_d = ST_WR;
         end
         ST_WR: begin
            avm_write     = 1'b1;
            avm_address   = cur_addr;
            avm_writedata = beat_q;
            if (last_beat)
               avm_byteenable = LAST_BE;
            if (!avm_waitrequest) begin
               if (last_beat) begin
                  adv     = 1'b1;
                  clr     = 1'b1;
                  state_d = last_line ? DONE : ST_RRF;
               end else begin
                  inc = 1'b1;
               end
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_rf_ldst_dma.sv
// Directed bench for rf_ldst_dma with SDRAM and RF behavioural models.
module tb_rf_ldst_dma;

   localparam int BEATS = 11;

   typedef struct {
      logic [24:0]  a;
      logic [127:0] d;
      logic [15:0]  be;
   } wr_t;

   typedef struct {
      logic [8:0]    a;
      logic [1399:0] d;
   } rfw_t;

   logic          clk = 0;
   logic          rst_n = 0;
   logic [24:0]   cmd_sdram_addr = '0;
   logic [8:0]    cmd_rf_addr = '0;
   logic [7:0]    cmd_line_num = '0;
   logic [24:0]   cmd_stride = '0;
   logic          cmd_load = 0;
   logic          cmd_store = 0;
   logic          busy, done;
   logic [24:0]   avm_address;
   logic          avm_read, avm_write;
   logic [127:0]  avm_writedata;
   logic [15:0]   avm_byteenable;
   logic [4:0]    avm_burstcount;
   logic          avm_waitrequest = 0;
   logic [127:0]  avm_readdata = '0;
   logic          avm_readdatavalid = 0;
   logic [8:0]    rf_addr;
   logic [1399:0] rf_d;
   logic          rf_we, rf_re;
   logic [1399:0] rf_q = '1;

   int passed = 0;
   int total = 0;

   logic [24:0]  rd_q[$];
   wr_t          wr_q[$];
   rfw_t         rfw_q[$];
   logic [127:0] mem[logic [24:0]];
   int           done_cnt = 0;
   int           stall_err = 0;
   bit           wr_rand = 0;

   int           rd_pend = 0;
   logic [24:0]  rd_addr = '0;
   bit           re_pend = 0;
   logic [8:0]   re_addr = '0;
   bit           stall_prev = 0;
   logic [127:0] hold_d = '0;
   logic [24:0]  hold_a = '0;
   int           wr_idx = 0;

   rf_ldst_dma #(
      .SDRAM_ADDR_W (25),
      .SDRAM_DATA_W (128),
      .RF_ADDR_W    (9),
      .RF_DATA_W    (1400),
      .LINE_CNT_W   (8)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .cmd_sdram_addr    (cmd_sdram_addr),
      .cmd_rf_addr       (cmd_rf_addr),
      .cmd_line_num      (cmd_line_num),
      .cmd_stride        (cmd_stride),
      .cmd_load          (cmd_load),
      .cmd_store         (cmd_store),
      .busy              (busy),
      .done              (done),
      .avm_address       (avm_address),
      .avm_read          (avm_read),
      .avm_write         (avm_write),
      .avm_writedata     (avm_writedata),
      .avm_byteenable    (avm_byteenable),
      .avm_burstcount    (avm_burstcount),
      .avm_waitrequest   (avm_waitrequest),
      .avm_readdata      (avm_readdata),
      .avm_readdatavalid (avm_readdatavalid),
      .rf_addr           (rf_addr),
      .rf_d              (rf_d),
      .rf_we             (rf_we),
      .rf_re             (rf_re),
      .rf_q              (rf_q)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] sd_word(input logic [24:0] a, input int b);
      return {7'd0, a, 32'(b), ~{7'd0, a}, 32'hC0DE_0000 + 32'(b)};
   endfunction

   function automatic logic [1399:0] exp_line(input logic [24:0] a);
      logic [1407:0] t;
      for (int b = 0; b < BEATS; b++) t[b*128 +: 128] = sd_word(a, b);
      return t[1399:0];
   endfunction

   function automatic logic [1399:0] rf_pat(input logic [8:0] a);
      logic [1407:0] t;
      for (int i = 0; i < 44; i++)
         t[i*32 +: 32] = {16'hBEEF ^ 16'(a), 8'(i), 8'h5A};
      return t[1399:0];
   endfunction

   function automatic logic [127:0] st_beat(input logic [8:0] a, input int b);
      logic [1407:0] t;
      t = {8'h00, rf_pat(a)};
      return t[b*128 +: 128];
   endfunction

   // SDRAM slave and RF models: inputs change at the falling edge
   always @(negedge clk) begin
      if (re_pend) begin
         rf_q = rf_pat(re_addr);
         re_pend = 0;
      end else begin
         rf_q = '1;
      end
      if (rf_re) begin
         re_pend = 1;
         re_addr = rf_addr;
      end
      if (rd_pend > 0) begin
         avm_readdatavalid = 1;
         avm_readdata = sd_word(rd_addr, BEATS - rd_pend);
         rd_pend--;
      end else begin
         avm_readdatavalid = 0;
         avm_readdata = '0;
      end
      avm_waitrequest = wr_rand ? 1'($urandom_range(0, 1)) : 1'b0;
      if (avm_read && !avm_waitrequest) begin
         rd_q.push_back(avm_address);
         rd_addr = avm_address;
         rd_pend = BEATS;
      end
      if (avm_write) begin
         if (stall_prev && (avm_writedata !== hold_d || avm_address !== hold_a))
            stall_err++;
         if (avm_waitrequest) begin
            stall_prev = 1;
            hold_d = avm_writedata;
            hold_a = avm_address;
         end else begin
            stall_prev = 0;
            wr_q.push_back('{avm_address, avm_writedata, avm_byteenable});
            mem[avm_address + 25'(16 * wr_idx)] = avm_writedata;
            wr_idx = (wr_idx == BEATS - 1) ? 0 : wr_idx + 1;
         end
      end else begin
         stall_prev = 0;
      end
      if (rf_we) rfw_q.push_back('{rf_addr, rf_d});
      if (done) done_cnt++;
      if (!rst_n) begin
         rd_pend = 0;
         re_pend = 0;
         stall_prev = 0;
         wr_idx = 0;
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic issue(input bit ld, input bit st, input logic [24:0] sa,
                        input logic [8:0] ra, input logic [7:0] n,
                        input logic [24:0] sd);
      cmd_sdram_addr = sa;
      cmd_rf_addr = ra;
      cmd_line_num = n;
      cmd_stride = sd;
      cmd_load = ld;
      cmd_store = st;
      step();
      cmd_load = 0;
      cmd_store = 0;
   endtask

   task automatic wait_done(input int maxc, output int n, output bit ok);
      ok = 0;
      n = 1;
      while (n <= maxc) begin
         if (done) begin
            ok = 1;
            break;
         end
         step();
         n++;
      end
   endtask

   task automatic test_reset();
      step();
      step();
      total++;
      if (busy !== 0 || done !== 0 || avm_read !== 0 || avm_write !== 0)
         $display("FAIL rst_ctrl got busy=%b done=%b rd=%b wr=%b exp 0000",
                  busy, done, avm_read, avm_write);
      else passed++;
      total++;
      if (avm_byteenable !== 16'hFFFF || avm_burstcount !== 5'd11)
         $display("FAIL rst_bus got be=%h bc=%0d exp ffff/11",
                  avm_byteenable, avm_burstcount);
      else passed++;
      total++;
      if (avm_address !== 0 || avm_writedata !== 0 || rf_we !== 0 ||
          rf_re !== 0 || rf_addr !== 0 || rf_d !== 0)
         $display("FAIL rst_data got addr=%h rf_we=%b rf_re=%b rf_addr=%0d exp zeros",
                  avm_address, rf_we, rf_re, rf_addr);
      else passed++;
      rst_n = 1;
      step();
   endtask

   task automatic test_load_multi();
      int rb, fb, db, n;
      bit ok;
      rb = rd_q.size();
      fb = rfw_q.size();
      db = done_cnt;
      issue(1, 0, 25'h100, 9'd5, 8'd3, 25'h200);
      wait_done(300, n, ok);
      total++;
      if (!ok || n != 40) $display("FAIL ld_latency got %0d (ok=%0b) exp 40", n, ok);
      else passed++;
      step();
      total++;
      if (rd_q.size() - rb != 3) $display("FAIL ld_nreq got %0d exp 3", rd_q.size() - rb);
      else passed++;
      total++;
      if (rfw_q.size() - fb != 3) $display("FAIL ld_nwe got %0d exp 3", rfw_q.size() - fb);
      else passed++;
      for (int l = 0; l < 3; l++) begin
         logic [24:0] ea;
         ea = 25'h100 + 25'(l * 'h200);
         total++;
         if (rd_q.size() > rb + l && rd_q[rb+l] !== ea)
            $display("FAIL ld_addr%0d got %h exp %h", l, rd_q[rb+l], ea);
         else if (rd_q.size() > rb + l) passed++;
         else $display("FAIL ld_addr%0d got none exp %h", l, ea);
         total++;
         if (rfw_q.size() <= fb + l)
            $display("FAIL ld_rf%0d got none exp write", l);
         else if (rfw_q[fb+l].a !== 9'(5 + l) || rfw_q[fb+l].d !== exp_line(ea))
            $display("FAIL ld_rf%0d got addr %0d exp %0d (data differs=%0b)", l,
                     rfw_q[fb+l].a, 5 + l, rfw_q[fb+l].d !== exp_line(ea));
         else passed++;
      end
      total++;
      if (done_cnt - db != 1 || busy !== 0)
         $display("FAIL ld_done got %0d pulses busy=%b exp 1/0", done_cnt - db, busy);
      else passed++;
   endtask

   task automatic test_store_pad();
      int wb, n;
      bit ok;
      wb = wr_q.size();
      issue(0, 1, 25'h4000, 9'd20, 8'd2, 25'h1000);
      wait_done(300, n, ok);
      total++;
      if (!ok || n != 27) $display("FAIL st_latency got %0d (ok=%0b) exp 27", n, ok);
      else passed++;
      step();
      total++;
      if (wr_q.size() - wb != 22) $display("FAIL st_nbeats got %0d exp 22", wr_q.size() - wb);
      else passed++;
      for (int i = 0; i < 22 && wb + i < wr_q.size(); i++) begin
         int l, b;
         logic [24:0] ea;
         logic [15:0] eb;
         l = i / BEATS;
         b = i % BEATS;
         ea = 25'h4000 + 25'(l * 'h1000);
         eb = (b == BEATS - 1) ? 16'h7FFF : 16'hFFFF;
         total++;
         if (wr_q[wb+i].a !== ea || wr_q[wb+i].be !== eb ||
             wr_q[wb+i].d !== st_beat(9'(20 + l), b))
            $display("FAIL st_beat%0d got a=%h be=%h d=%h exp a=%h be=%h d=%h", i,
                     wr_q[wb+i].a, wr_q[wb+i].be, wr_q[wb+i].d,
                     ea, eb, st_beat(9'(20 + l), b));
         else passed++;
      end
      if (wr_q.size() >= wb + 22) begin
         logic [127:0] d;
         d = wr_q[wb+21].d;
         total++;
         if (d[127:120] !== 8'h00) $display("FAIL st_pad got %h exp 00", d[127:120]);
         else passed++;
      end
   endtask

   task automatic test_random_wait();
      int wb, sb, n;
      bit ok;
      wb = wr_q.size();
      sb = stall_err;
      wr_rand = 1;
      issue(0, 1, 25'h10000, 9'd100, 8'd4, 25'h800);
      wait_done(3000, n, ok);
      wr_rand = 0;
      step();
      total++;
      if (!ok) $display("FAIL rw_done got timeout exp done");
      else passed++;
      total++;
      if (wr_q.size() - wb != 44) $display("FAIL rw_nbeats got %0d exp 44", wr_q.size() - wb);
      else passed++;
      total++;
      if (stall_err != sb) $display("FAIL rw_stable got %0d changes exp 0", stall_err - sb);
      else passed++;
      for (int l = 0; l < 4; l++) begin
         int bad;
         bad = 0;
         for (int b = 0; b < BEATS; b++) begin
            logic [24:0] a;
            a = 25'h10000 + 25'(l * 'h800) + 25'(b * 16);
            if (!mem.exists(a)) bad++;
            else if (mem[a] !== st_beat(9'(100 + l), b)) bad++;
         end
         total++;
         if (bad != 0) $display("FAIL rw_line%0d got %0d bad beats exp 0", l, bad);
         else passed++;
      end
   endtask

   task automatic test_zero_lines();
      int rb, fb;
      rb = rd_q.size();
      fb = rfw_q.size();
      issue(1, 0, 25'h200, 9'd3, 8'd0, 25'h10);
      total++;
      if (done !== 1 || busy !== 1) $display("FAIL z_done got done=%b busy=%b exp 1/1", done, busy);
      else passed++;
      step();
      total++;
      if (done !== 0 || busy !== 0) $display("FAIL z_idle got done=%b busy=%b exp 0/0", done, busy);
      else passed++;
      total++;
      if (rd_q.size() != rb || rfw_q.size() != fb)
         $display("FAIL z_quiet got %0d reads %0d rf writes exp 0/0",
                  rd_q.size() - rb, rfw_q.size() - fb);
      else passed++;
   endtask

   task automatic test_both_cmd();
      int rb, fb, wb, n;
      bit ok;
      rb = rd_q.size();
      fb = rfw_q.size();
      wb = wr_q.size();
      issue(1, 1, 25'h8000, 9'd511, 8'd2, 25'h40);
      step();
      issue(0, 1, 25'h9000, 9'd50, 8'd1, 25'h0);
      wait_done(300, n, ok);
      for (int i = 0; i < 4; i++) step();
      total++;
      if (!ok || busy !== 0) $display("FAIL bc_done got ok=%0b busy=%b exp 1/0", ok, busy);
      else passed++;
      total++;
      if (wr_q.size() != wb) $display("FAIL bc_nowrite got %0d beats exp 0", wr_q.size() - wb);
      else passed++;
      total++;
      if (rd_q.size() - rb != 2 || rd_q[rb] !== 25'h8000 || rd_q[rb+1] !== 25'h8040)
         $display("FAIL bc_reads got %0d reads exp 2 at 8000/8040", rd_q.size() - rb);
      else passed++;
      total++;
      if (rfw_q.size() - fb != 2)
         $display("FAIL bc_nwe got %0d exp 2", rfw_q.size() - fb);
      else if (rfw_q[fb].a !== 9'd511 || rfw_q[fb+1].a !== 9'd0)
         $display("FAIL bc_wrap got %0d,%0d exp 511,0", rfw_q[fb].a, rfw_q[fb+1].a);
      else passed++;
      total++;
      if (rfw_q.size() - fb == 2 &&
          (rfw_q[fb].d !== exp_line(25'h8000) || rfw_q[fb+1].d !== exp_line(25'h8040)))
         $display("FAIL bc_data got mismatching rf lines exp sdram lines 8000/8040");
      else if (rfw_q.size() - fb == 2) passed++;
      else $display("FAIL bc_data got %0d lines exp 2", rfw_q.size() - fb);
   endtask

   task automatic test_reset_mid();
      int fb, db, n;
      bit ok;
      issue(1, 0, 25'h600, 9'd7, 8'd1, 25'h0);
      for (int i = 0; i < 4; i++) step();
      db = done_cnt;
      rst_n = 0;
      #1;
      total++;
      if (busy !== 0 || avm_read !== 0 || rf_we !== 0 || avm_address !== 0 ||
          avm_byteenable !== 16'hFFFF)
         $display("FAIL rm_outs got busy=%b rd=%b we=%b a=%h be=%h exp 0/0/0/0/ffff",
                  busy, avm_read, rf_we, avm_address, avm_byteenable);
      else passed++;
      step();
      step();
      rst_n = 1;
      step();
      total++;
      if (done_cnt != db) $display("FAIL rm_nodone got %0d pulses exp 0", done_cnt - db);
      else passed++;
      fb = rfw_q.size();
      db = done_cnt;
      issue(1, 0, 25'h700, 9'd9, 8'd1, 25'h0);
      wait_done(300, n, ok);
      step();
      total++;
      if (!ok || n != 14) $display("FAIL rm_latency got %0d (ok=%0b) exp 14", n, ok);
      else passed++;
      total++;
      if (rfw_q.size() - fb != 1 || done_cnt - db != 1)
         $display("FAIL rm_count got %0d writes %0d done exp 1/1",
                  rfw_q.size() - fb, done_cnt - db);
      else if (rfw_q[fb].a !== 9'd9 || rfw_q[fb].d !== exp_line(25'h700))
         $display("FAIL rm_data got addr %0d exp 9 (data differs=%0b)",
                  rfw_q[fb].a, rfw_q[fb].d !== exp_line(25'h700));
      else passed++;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_load_multi();
      test_store_pad();
      test_random_wait();
      test_zero_lines();
      test_both_cmd();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
